// File: rtl/riscv_pkg.sv
// Shared rv32i definitions: opcodes, load/store width codes, LSU state type
// and the access legality helpers used by the load/store unit.
package riscvPkg;

    localparam logic [6:0] OpImmLoad = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;

    localparam logic [2:0] DataByte  = 3'b000;
    localparam logic [2:0] DataHalf  = 3'b001;
    localparam logic [2:0] DataWord  = 3'b010;
    localparam logic [2:0] DataByteU = 3'b100;
    localparam logic [2:0] DataHalfU = 3'b101;

    typedef enum logic [1:0] {
        LsuIdle = 2'd0,
        LsuMem  = 2'd1,
        LsuResp = 2'd2
    } lsuState_e;

    // Stores have no unsigned variants, so the legal sets differ by direction.
    function automatic logic isIllegal(input logic store, input logic [2:0] funct3);
        logic illegal;
        illegal = 1'b1;
        case (funct3)
            DataByte, DataHalf, DataWord: illegal = 1'b0;
            DataByteU, DataHalfU:         illegal = store;
            default:                      illegal = 1'b1;
        endcase
        return illegal;
    endfunction

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic misaligned;
        misaligned = 1'b0;
        case (funct3)
            DataHalf, DataHalfU: misaligned = offset[0];
            DataWord:            misaligned = |offset;
            default:             misaligned = 1'b0;
        endcase
        return misaligned;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute, data-memory and writeback signals of the load/store unit.
// The master modport is the LSU's view; slave is the surrounding pipeline.
interface lsu_if #(parameter int XLEN = 32);

    logic            i_ex_valid;
    logic            o_ex_ready;
    logic            i_ex_store;
    logic [2:0]      i_ex_funct3;
    logic [XLEN-1:0] i_ex_addr;
    logic [XLEN-1:0] i_ex_wdata;
    logic [4:0]      i_ex_rd;

    logic            o_dmem_req;
    logic            o_dmem_we;
    logic [XLEN-1:0] o_dmem_addr;
    logic [3:0]      o_dmem_wstrb;
    logic [XLEN-1:0] o_dmem_wdata;
    logic            i_dmem_ack;
    logic [XLEN-1:0] i_dmem_rdata;

    logic            o_wb_valid;
    logic            i_wb_ready;
    logic            o_wb_we;
    logic [4:0]      o_wb_rd;
    logic [XLEN-1:0] o_wb_data;
    logic            o_wb_misalign;
    logic            o_wb_illegal;

    modport master (
        input  i_ex_valid, i_ex_store, i_ex_funct3, i_ex_addr, i_ex_wdata, i_ex_rd,
        output o_ex_ready,
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wstrb, o_dmem_wdata,
        input  i_dmem_ack, i_dmem_rdata,
        output o_wb_valid, o_wb_we, o_wb_rd, o_wb_data, o_wb_misalign, o_wb_illegal,
        input  i_wb_ready
    );

    modport slave (
        output i_ex_valid, i_ex_store, i_ex_funct3, i_ex_addr, i_ex_wdata, i_ex_rd,
        input  o_ex_ready,
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wstrb, o_dmem_wdata,
        output i_dmem_ack, i_dmem_rdata,
        input  o_wb_valid, o_wb_we, o_wb_rd, o_wb_data, o_wb_misalign, o_wb_illegal,
        output i_wb_ready
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/replication on one side,
// load lane selection and sign/zero extension on the other.
module lsu_align
    import riscvPkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      stOffset_i,
    input  logic [2:0]      stFunct3_i,
    input  logic [XLEN-1:0] stWdata_i,
    output logic [3:0]      stWstrb_o,
    output logic [XLEN-1:0] stWdata_o,

    input  logic [1:0]      ldOffset_i,
    input  logic [2:0]      ldFunct3_i,
    input  logic [XLEN-1:0] ldRdata_i,
    output logic [XLEN-1:0] ldData_o
);

    logic [15:0] ldShifted;

    // Narrow store data is replicated so every lane carries it; the strobe picks the lane.
    always_comb begin
        stWstrb_o = 4'b1111;
        stWdata_o = stWdata_i;
        case (stFunct3_i)
            DataByte: begin
                stWstrb_o = 4'b0001 << stOffset_i;
                stWdata_o = {4{stWdata_i[7:0]}};
            end
            DataHalf: begin
                stWstrb_o = 4'b0011 << stOffset_i;
                stWdata_o = {2{stWdata_i[15:0]}};
            end
            default: begin
                stWstrb_o = 4'b1111;
                stWdata_o = stWdata_i;
            end
        endcase
    end

    always_comb begin
        ldShifted = 16'(ldRdata_i >> {ldOffset_i, 3'b000});
        ldData_o  = ldRdata_i;
        case (ldFunct3_i)
            DataByte:  ldData_o = {{(XLEN-8){ldShifted[7]}}, ldShifted[7:0]};
            DataHalf:  ldData_o = {{(XLEN-16){ldShifted[15]}}, ldShifted};
            DataByteU: ldData_o = {{(XLEN-8){1'b0}}, ldShifted[7:0]};
            DataHalfU: ldData_o = {{(XLEN-16){1'b0}}, ldShifted};
            default:   ldData_o = ldRdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit for the rv32i memory stage: one outstanding data-memory
// request, error responses for illegal or misaligned accesses.
module lsu
    import riscvPkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic  i_clk,
    input  logic  i_rstn,
    lsu_if.master bus
);

    lsuState_e       state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            store_q, store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wbData_q, wbData_d;
    logic            wbWe_q, wbWe_d;
    logic            misalign_q, misalign_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      stWstrb;
    logic [XLEN-1:0] stWdata;
    logic [XLEN-1:0] ldData;
    logic            exIllegal;
    logic            exMisalign;

    lsu_align #(.XLEN(XLEN)) u_align (
        .stOffset_i (bus.i_ex_addr[1:0]),
        .stFunct3_i (bus.i_ex_funct3),
        .stWdata_i  (bus.i_ex_wdata),
        .stWstrb_o  (stWstrb),
        .stWdata_o  (stWdata),
        .ldOffset_i (addr_q[1:0]),
        .ldFunct3_i (funct3_q),
        .ldRdata_i  (bus.i_dmem_rdata),
        .ldData_o   (ldData)
    );

    assign exIllegal  = isIllegal(bus.i_ex_store, bus.i_ex_funct3);
    assign exMisalign = !exIllegal && isMisaligned(bus.i_ex_funct3, bus.i_ex_addr[1:0]);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= LsuIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            store_q    <= 1'b0;
            funct3_q   <= '0;
            rd_q       <= '0;
            wbData_q   <= '0;
            wbWe_q     <= 1'b0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            store_q    <= store_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            wbData_q   <= wbData_d;
            wbWe_q     <= wbWe_d;
            misalign_q <= misalign_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        store_d    = store_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        wbData_d   = wbData_q;
        wbWe_d     = wbWe_q;
        misalign_d = misalign_q;
        illegal_d  = illegal_q;

        case (state_q)
            LsuIdle: begin
                if (bus.i_ex_valid) begin
                    addr_d     = bus.i_ex_addr;
                    store_d    = bus.i_ex_store;
                    funct3_d   = bus.i_ex_funct3;
                    rd_d       = bus.i_ex_rd;
                    wdata_d    = bus.i_ex_store ? stWdata : '0;
                    // Rejected accesses never reach memory, so no strobes are kept for them.
                    wstrb_d    = (bus.i_ex_store && !exIllegal && !exMisalign) ? stWstrb : 4'b0000;
                    illegal_d  = exIllegal;
                    misalign_d = exMisalign;
                    wbData_d   = '0;
                    wbWe_d     = 1'b0;
                    state_d    = (exIllegal || exMisalign) ? LsuResp : LsuMem;
                end
            end
            LsuMem: begin
                if (bus.i_dmem_ack) begin
                    wbData_d = store_q ? '0 : ldData;
                    wbWe_d   = !store_q && (rd_q != 5'd0);
                    state_d  = LsuResp;
                end
            end
            LsuResp: begin
                if (bus.i_wb_ready) begin
                    state_d = LsuIdle;
                end
            end
            default: state_d = LsuIdle;
        endcase
    end

    assign bus.o_ex_ready    = (state_q == LsuIdle);
    assign bus.o_dmem_req    = (state_q == LsuMem);
    assign bus.o_dmem_we     = store_q;
    assign bus.o_dmem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign bus.o_dmem_wstrb  = wstrb_q;
    assign bus.o_dmem_wdata  = wdata_q;
    assign bus.o_wb_valid    = (state_q == LsuResp);
    assign bus.o_wb_we       = wbWe_q;
    assign bus.o_wb_rd       = rd_q;
    assign bus.o_wb_data     = wbData_q;
    assign bus.o_wb_misalign = misalign_q;
    assign bus.o_wb_illegal  = illegal_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed test-plan accesses, an asynchronous
// reset during a request, then randomized accesses against a byte-level model.
module tb_lsu;

    logic clk;
    logic rstn;
    int   testsRun;
    int   testsFailed;

    lsu_if #(.XLEN(32)) bus ();

    lsu #(.XLEN(32)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Bytes touched by an access: 1, 2 or 4 depending on the width code.
    function automatic int accessSize(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic refLegal(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] f3, input int off, input logic [31:0] rdata);
        int     size;
        longint v;
        size = accessSize(f3);
        v    = 0;
        for (int i = 0; i < size; i++) begin
            v += longint'(rdata[8*(off+i) +: 8]) << (8*i);
        end
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size - 1))) begin
            v -= (longint'(1) << (8*size));
        end
        return v[31:0];
    endfunction

    task automatic applyStimulus(input string tag, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                                 input int reqCycles, input logic [31:0] rdata, input int readyDelay,
                                 output logic [31:0] gotData);
        int          size;
        int          off;
        logic        legal;
        logic        aligned;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
        logic [31:0] expData;
        logic        expWe;

        size     = accessSize(f3);
        off      = int'(addr[1:0]);
        legal    = refLegal(st, f3);
        aligned  = (off % size) == 0;
        expStrb  = 4'b0000;
        expWdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k >= off && k < off + size) expStrb[k] = 1'b1;
            expWdata[8*k +: 8] = wd[8*((k + 4 - off) % size) +: 8];
        end
        expData = (legal && aligned && !st) ? refLoad(f3, off, rdata) : 32'h0;
        expWe   = legal && aligned && !st && (rd != 5'd0);
        gotData = 32'h0;

        @(negedge clk);
        checkOutput({tag, ".exReady"}, {31'h0, bus.o_ex_ready}, 32'd1);
        bus.i_ex_valid  = 1'b1;
        bus.i_ex_store  = st;
        bus.i_ex_funct3 = f3;
        bus.i_ex_addr   = addr;
        bus.i_ex_wdata  = wd;
        bus.i_ex_rd     = rd;
        @(negedge clk);
        bus.i_ex_valid  = 1'b0;
        bus.i_ex_addr   = $urandom;
        bus.i_ex_wdata  = $urandom;

        if (legal && aligned) begin
            for (int i = 0; i < reqCycles; i++) begin
                checkOutput({tag, ".dmemReq"}, {31'h0, bus.o_dmem_req}, 32'd1);
                checkOutput({tag, ".wbValidMem"}, {31'h0, bus.o_wb_valid}, 32'd0);
                if (i == 0) begin
                    checkOutput({tag, ".dmemAddr"}, bus.o_dmem_addr, {addr[31:2], 2'b00});
                    checkOutput({tag, ".dmemWe"}, {31'h0, bus.o_dmem_we}, {31'h0, st});
                    checkOutput({tag, ".dmemWstrb"}, {28'h0, bus.o_dmem_wstrb}, st ? {28'h0, expStrb} : 32'h0);
                    if (st) checkOutput({tag, ".dmemWdata"}, bus.o_dmem_wdata, expWdata);
                end
                if (i == reqCycles - 1) begin
                    bus.i_dmem_ack   = 1'b1;
                    bus.i_dmem_rdata = rdata;
                end else begin
                    bus.i_dmem_rdata = $urandom;
                end
                @(negedge clk);
                bus.i_dmem_ack   = 1'b0;
                bus.i_dmem_rdata = $urandom;
            end
        end
        checkOutput({tag, ".dmemReqOff"}, {31'h0, bus.o_dmem_req}, 32'd0);
        checkOutput({tag, ".wbValid"}, {31'h0, bus.o_wb_valid}, 32'd1);
        checkOutput({tag, ".wbWe"}, {31'h0, bus.o_wb_we}, {31'h0, expWe});
        checkOutput({tag, ".wbRd"}, {27'h0, bus.o_wb_rd}, {27'h0, rd});
        checkOutput({tag, ".wbData"}, bus.o_wb_data, expData);
        checkOutput({tag, ".illegal"}, {31'h0, bus.o_wb_illegal}, {31'h0, !legal});
        checkOutput({tag, ".misalign"}, {31'h0, bus.o_wb_misalign}, {31'h0, legal && !aligned});
        gotData = bus.o_wb_data;

        for (int i = 0; i < readyDelay; i++) begin
            @(negedge clk);
            checkOutput({tag, ".holdValid"}, {31'h0, bus.o_wb_valid}, 32'd1);
            checkOutput({tag, ".holdData"}, bus.o_wb_data, expData);
            checkOutput({tag, ".holdExReady"}, {31'h0, bus.o_ex_ready}, 32'd0);
        end
        bus.i_wb_ready = 1'b1;
        @(negedge clk);
        bus.i_wb_ready = 1'b0;
        checkOutput({tag, ".wbValidDone"}, {31'h0, bus.o_wb_valid}, 32'd0);
        checkOutput({tag, ".exReadyBack"}, {31'h0, bus.o_ex_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic        st;
        logic [2:0]  f3;

        testsRun         = 0;
        testsFailed      = 0;
        rstn             = 1'b0;
        bus.i_ex_valid   = 1'b0;
        bus.i_ex_store   = 1'b0;
        bus.i_ex_funct3  = 3'd0;
        bus.i_ex_addr    = 32'h0;
        bus.i_ex_wdata   = 32'h0;
        bus.i_ex_rd      = 5'd0;
        bus.i_dmem_ack   = 1'b0;
        bus.i_dmem_rdata = 32'h0;
        bus.i_wb_ready   = 1'b0;

        #3;
        checkOutput("reset.exReady", {31'h0, bus.o_ex_ready}, 32'd1);
        checkOutput("reset.dmemReq", {31'h0, bus.o_dmem_req}, 32'd0);
        checkOutput("reset.dmemWe", {31'h0, bus.o_dmem_we}, 32'd0);
        checkOutput("reset.dmemAddr", bus.o_dmem_addr, 32'h0);
        checkOutput("reset.dmemWstrb", {28'h0, bus.o_dmem_wstrb}, 32'h0);
        checkOutput("reset.dmemWdata", bus.o_dmem_wdata, 32'h0);
        checkOutput("reset.wbValid", {31'h0, bus.o_wb_valid}, 32'd0);
        checkOutput("reset.wbData", bus.o_wb_data, 32'h0);
        checkOutput("reset.wbRd", {27'h0, bus.o_wb_rd}, 32'h0);
        checkOutput("reset.flags", {30'h0, bus.o_wb_misalign, bus.o_wb_illegal}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        applyStimulus("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 3, 32'h0, 0, got);
        applyStimulus("sb", 1'b1, 3'b000, 32'h203, 32'h000000A5, 5'd2, 1, 32'h0, 0, got);
        applyStimulus("lb", 1'b0, 3'b000, 32'h103, 32'h0, 5'd3, 1, 32'h80F07F01, 0, got);
        checkOutput("plan.lb", got, 32'hFFFFFF80);
        applyStimulus("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 5'd4, 2, 32'h80F07F01, 0, got);
        checkOutput("plan.lbu", got, 32'h00000080);
        applyStimulus("lh", 1'b0, 3'b001, 32'h102, 32'h0, 5'd5, 1, 32'h80F07F01, 1, got);
        checkOutput("plan.lh", got, 32'hFFFF80F0);
        applyStimulus("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 5'd0, 1, 32'h80F07F01, 0, got);
        checkOutput("plan.lhu", got, 32'h00007F01);
        applyStimulus("lwMis", 1'b0, 3'b010, 32'h102, 32'h0, 5'd6, 1, 32'h0, 0, got);
        applyStimulus("shIll", 1'b1, 3'b011, 32'h104, 32'h1234, 5'd7, 1, 32'h0, 0, got);
        applyStimulus("lwStall", 1'b0, 3'b010, 32'h108, 32'h0, 5'd8, 1, 32'hCAFEF00D, 4, got);
        checkOutput("plan.lwStall", got, 32'hCAFEF00D);

        // Asynchronous reset while a request is outstanding.
        @(negedge clk);
        bus.i_ex_valid  = 1'b1;
        bus.i_ex_store  = 1'b1;
        bus.i_ex_funct3 = 3'b010;
        bus.i_ex_addr   = 32'h300;
        bus.i_ex_wdata  = 32'h11223344;
        bus.i_ex_rd     = 5'd9;
        @(negedge clk);
        bus.i_ex_valid = 1'b0;
        checkOutput("rst.reqBefore", {31'h0, bus.o_dmem_req}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("rst.req", {31'h0, bus.o_dmem_req}, 32'd0);
        checkOutput("rst.we", {31'h0, bus.o_dmem_we}, 32'd0);
        checkOutput("rst.addr", bus.o_dmem_addr, 32'h0);
        checkOutput("rst.wstrb", {28'h0, bus.o_dmem_wstrb}, 32'h0);
        checkOutput("rst.wdata", bus.o_dmem_wdata, 32'h0);
        checkOutput("rst.exReady", {31'h0, bus.o_ex_ready}, 32'd1);
        checkOutput("rst.wbValid", {31'h0, bus.o_wb_valid}, 32'd0);
        @(negedge clk);
        rstn           = 1'b1;
        bus.i_dmem_ack = 1'b1;
        @(negedge clk);
        bus.i_dmem_ack = 1'b0;
        checkOutput("rst.lateAckValid", {31'h0, bus.o_wb_valid}, 32'd0);
        checkOutput("rst.lateAckReq", {31'h0, bus.o_dmem_req}, 32'd0);
        @(negedge clk);
        checkOutput("rst.idleValid", {31'h0, bus.o_wb_valid}, 32'd0);
        checkOutput("rst.idleReady", {31'h0, bus.o_ex_ready}, 32'd1);

        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            applyStimulus("rand", st, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                          $urandom_range(1, 4), $urandom, $urandom_range(0, 3), got);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the rv32i core's memory stage. It takes one load or store from the execute stage, containing the effective address, store data, funct3 and rd. It drives a single-outstanding data-memory request with byte strobes, then aligns and sign- or zero-extends the returned word. The result goes to writeback through a valid/ready handshake. Misaligned and unsupported-width accesses never reach memory and return an error response instead.

## Interface
Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_ex_valid  in  1  execute stage presents an access.
- o_ex_ready  out  1  LSU can accept an access; high only in IDLE.
- i_ex_store  in  1  1 = store (OpStore), 0 = load (OpImmLoad).
- i_ex_funct3  in  3  width code, using DataByte, DataHalf, DataWord, DataByteU or DataHalfU.
- i_ex_addr  in  XLEN  effective byte address.
- i_ex_wdata  in  XLEN  store data (rs2), value in the low lanes.
- i_ex_rd  in  5  destination register.
- o_dmem_req  out  1  memory request, held until acknowledged.
- o_dmem_we  out  1  write enable.
- o_dmem_addr  out  XLEN  word address, equal to {addr[31:2], 2'b00}.
- o_dmem_wstrb  out  4  byte strobes; 0000 on loads.
- o_dmem_wdata  out  XLEN  store data shifted into the addressed lanes.
- i_dmem_ack  in  1  memory completes the request; rdata is valid this cycle.
- i_dmem_rdata  in  XLEN  read word.
- o_wb_valid  out  1  response available.
- i_wb_ready  in  1  writeback accepts the response.
- o_wb_we  out  1  write rd; 1 only for a successful load with rd≠0.
- o_wb_rd  out  5  destination register.
- o_wb_data  out  XLEN  extended load data; 0 for stores and errors.
- o_wb_misalign  out  1  address misaligned for the requested width.
- o_wb_illegal  out  1  unsupported funct3.

## Operation
- FSM states:
  - LsuIdle: o_ex_ready=1.
  - LsuMem: o_dmem_req=1.
  - LsuResp: o_wb_valid=1.
- Transitions:
  - Idle→Mem on i_ex_valid when the access is legal and aligned.
  - Idle→Resp on i_ex_valid when the access is illegal or misaligned; no memory request is issued.
  - Mem→Resp on i_dmem_ack.
  - Resp→Idle on i_wb_ready.
- On acceptance, register the address, lane-shifted wdata, wstrb, store flag, funct3 and rd. The dmem outputs are driven from these registers only.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else sets o_wb_illegal, and o_wb_misalign=0.
- Alignment rules:
  - Half accesses require addr[0]=0.
  - Word accesses require addr[1:0]=0.
  - Byte accesses are always aligned.
- Store strobes:
  - SB: 0001<<addr[1:0], with wdata byte replicated to all lanes.
  - SH: 0011<<addr[1:0], with the half replicated.
  - SW: 1111.
- Loads: on ack, select the byte or half lane by addr[1:0], sign-extend for DataByte/DataHalf and zero-extend for the U variants, then register the result into o_wb_data.
- While in Resp, the response fields are stable until accepted.

## Timing
- Reset values: state Idle; o_ex_ready=1; o_dmem_req=0, o_dmem_we=0, o_dmem_wstrb=0, o_dmem_addr=0, o_dmem_wdata=0; o_wb_valid=0, o_wb_we=0, o_wb_rd=0, o_wb_data=0; both error flags 0.
- Access accepted at edge N.
  - o_dmem_req is high from cycle N+1.
  - A zero-wait ack in cycle N+1 gives o_wb_valid in cycle N+2.
  - Minimum latency from accept to response is therefore 2 cycles.
- Error response: o_wb_valid rises at N+1.
- With i_wb_ready held high, o_ex_ready returns in the cycle after the response handshake. Sustained throughput is one access per 3 cycles.
- i_dmem_ack is ignored outside Mem. Requests never overlap.
- If i_rstn is asserted mid-access, all outputs go to their reset values immediately, with no wait for a clock edge. A late ack after release is ignored.

## Structure
- Add the LSU state enum (LsuIdle, LsuMem, LsuResp) to riscvPkg as a typedef.
- Use the existing Data* funct3 constants and OpStore/OpImmLoad there; do not redefine them.
- Put the strobe, lane-shift and extend logic in one combinational sub-module, lsu_align. It has two independent halves: store side (addr, funct3, wdata → wstrb, wdata) and load side (addr, funct3, rdata → data).
- The lsu top contains the FSM and registers only.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ack after 3 cycles -> dmem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF; wb_valid with wb_we=0; req held exactly 3 cycles.
- SB addr 0x203, data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5, dmem_addr 0x200.
- rdata 0x80F07F01:
  - LB at addr+3 -> 0xFFFFFF80.
  - LBU at addr+3 -> 0x00000080.
  - LH at addr+2 -> 0xFFFF80F0.
  - LHU at addr+0 -> 0x00007F01.
- LW addr 0x102 -> no dmem_req; wb_valid at N+1 with misalign=1, wb_we=0. SH with funct3=011 -> illegal=1.
- Zero-wait ack, then i_wb_ready low for 4 cycles -> wb_valid and wb_data stable; o_ex_ready low until the handshake.
- i_rstn low during Mem -> dmem_req=0 immediately; an ack after release gives no wb_valid.
